room_plant: RTL and testbench
=============================

# room_plant

Behavioural thermal plant for the air-conditioning exercise: consumes the controller's `heating`/`cooling` commands and produces the 5-bit room temperature the controller reads back, closing the loop in simulation and on the board. Temperature moves up or down one degree per fixed number of cycles while a command is active, and drifts one degree toward an ambient value otherwise. It sits opposite the controller on the same `temp`/`heating`/`cooling` interface.

## Interface
- `TEMP_INIT`, 20: temperature loaded on reset (0..31).
- `AMBIENT`, 18: idle drift target (0..31).
- `STEP_CYCLES`, 4: cycles per 1-degree step while heating or cooling (≥2).
- `DRIFT_CYCLES`, 8: cycles per 1-degree drift step while idle (≥2).
- `TEMP_MIN`, 0 / `TEMP_MAX`, 31: saturation limits, `TEMP_MIN` < `TEMP_MAX`.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `heating`  in  1  heat command from controller.
- `cooling`  in  1  cool command from controller.
- `temp`  out  5  current room temperature, unsigned degrees.
- `temp_chg`  out  1  one-cycle pulse, coincident with every cycle in which `temp` takes a new value.
- `at_limit`  out  1  high while `temp` equals `TEMP_MIN` or `TEMP_MAX`.
- `fault`  out  1  high while state is FAULT.

## Operation
- States: IDLE, HEAT, COOL, FAULT. The next state comes from the sampled inputs only: both high gives FAULT, `heating` only gives HEAT, `cooling` only gives COOL, neither gives IDLE. Any state can move to any state in one edge.
- Step timer: the counter resets to 0 on every edge where the next state differs from the current state. It counts up otherwise, wraps at terminal count (`STEP_CYCLES`-1 in HEAT/COOL, `DRIFT_CYCLES`-1 in IDLE), and is held at 0 in FAULT.
- HEAT: on terminal count, `temp` increments. COOL: on terminal count, `temp` decrements.
- IDLE: on terminal count, `temp` moves one degree toward `AMBIENT`. There is no change when already at `AMBIENT`.
- FAULT: `temp` is frozen and `fault`=1.
- Saturation: an increment at `TEMP_MAX` or a decrement at `TEMP_MIN` is suppressed. The counter still wraps, and `temp_chg` stays 0.
- `temp_chg` is asserted only when the value actually changes.
- Arithmetic is 5-bit unsigned. The limit comparisons happen before the ±1, so wrap-around never occurs.

## Timing
- Reset values: `temp`=`TEMP_INIT`, state IDLE, counter 0, `temp_chg`=0, `fault`=0, `at_limit` follows `TEMP_INIT`.
- Reset mid-step discards the partial count. The first post-reset drift step occurs `DRIFT_CYCLES` edges after `rst` deasserts.
- Entry latency: if the command is sampled at edge k, `temp` changes at edge k+`STEP_CYCLES`, then every `STEP_CYCLES` edges after that.
- A command glitch shorter than the terminal count produces no step and restarts the count on each state change.
- All outputs are registered. `at_limit` and `fault` update on the same edge as `temp` and state.

## Configuration
- `PLANT_DISTURB_EN`: when defined, adds two ports.
  - `dist_req` (in, 1): pulse requesting a +1/−1 step.
  - `dist_up` (in, 1): direction of the step, 1 = up.
- A disturbance applies on the edge it is sampled, independent of the step timer, and obeys saturation.
- If a disturbance and a timer step land on the same edge, both apply (net 0, ±1 or ±2, clamped to limits). `temp_chg` is set only if the value changes.
- In FAULT, disturbances still apply.
- When the macro is undefined, the ports do not exist and behaviour is as above.

## Structure
- `thermo_pkg` holds:
  - the state enum (IDLE/HEAT/COOL/FAULT);
  - `TEMP_W`=5;
  - the default limit constants, which are shared with the controller bench.
- One sub-module, `step_timer`:
  - loadable counter with a runtime terminal count, synchronous clear and hold;
  - one-cycle `tc` output.

## Test plan
- Reset with defaults, all commands 0: `temp`=20, then 19 at 8 edges after reset, then 18 at 16 edges, then holds 18 with no further `temp_chg`.
- `heating`=1 from 20: `temp` reads 21, 22, 23 at 4, 8 and 12 edges after the command is sampled, with one `temp_chg` pulse per step.
- `heating`=1 from 30: `temp` reaches 31 and `at_limit`=1. Afterwards `temp_chg` never pulses and `temp` stays 31. The mirror case with `cooling` from 1 holds at 0.
- `heating`=`cooling`=1 for 10 cycles at 25: `fault`=1 and `temp` stays 25. After release into COOL, the first decrement comes 4 edges later.
- `heating` toggles every 3 cycles with `STEP_CYCLES`=4: `temp` never changes from its heating steps. Only idle drift can act, and it never fires because the count restarts.
- With `PLANT_DISTURB_EN`, a `dist_req` with `dist_up`=1 on the same edge as a HEAT step at 29: `temp` becomes 31 with a single `temp_chg`. The same event at 30 gives 31 with `at_limit`=1.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared types and default constants for the thermostat controller and the room plant.
package thermo_pkg;

    localparam int unsigned TEMP_W           = 5;
    localparam int unsigned TEMP_INIT_DEF    = 20;
    localparam int unsigned AMBIENT_DEF      = 18;
    localparam int unsigned STEP_CYCLES_DEF  = 4;
    localparam int unsigned DRIFT_CYCLES_DEF = 8;
    localparam int unsigned TEMP_MIN_DEF     = 0;
    localparam int unsigned TEMP_MAX_DEF     = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAT  = 2'd1,
        COOL  = 2'd2,
        FAULT = 2'd3
    } plant_state_t;

    // Plant mode is a pure function of the two controller commands.
    function automatic plant_state_t decode_cmd(input logic heating, input logic cooling);
        plant_state_t st;
        if (heating && cooling) begin
            st = FAULT;
        end else if (heating) begin
            st = HEAT;
        end else if (cooling) begin
            st = COOL;
        end else begin
            st = IDLE;
        end
        return st;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable up-counter with runtime terminal count, synchronous clear and hold.
// tc is a same-cycle flag marking the edge on which the counter wraps.
module step_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = !clr && !hold && !load && (count == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (hold) begin
            count <= count;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/room_plant.sv
// Behavioural room thermal plant driven by heating/cooling commands.
// Optional PLANT_DISTURB_EN adds dist_req/dist_up for external +/-1 steps.
module room_plant
    import thermo_pkg::*;
#(
    parameter int unsigned TEMP_INIT    = TEMP_INIT_DEF,
    parameter int unsigned AMBIENT      = AMBIENT_DEF,
    parameter int unsigned STEP_CYCLES  = STEP_CYCLES_DEF,
    parameter int unsigned DRIFT_CYCLES = DRIFT_CYCLES_DEF,
    parameter int unsigned TEMP_MIN     = TEMP_MIN_DEF,
    parameter int unsigned TEMP_MAX     = TEMP_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              heating,
    input  logic              cooling,
`ifdef PLANT_DISTURB_EN
    input  logic              dist_req,
    input  logic              dist_up,
`endif
    output logic [TEMP_W-1:0] temp,
    output logic              temp_chg,
    output logic              at_limit,
    output logic              fault
);

    localparam int unsigned CYC_MAX = (STEP_CYCLES > DRIFT_CYCLES) ? STEP_CYCLES : DRIFT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CYC_MAX);

    localparam logic [CNT_W-1:0]  STEP_TC  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRIFT_TC = CNT_W'(DRIFT_CYCLES - 1);
    localparam logic [TEMP_W-1:0] MIN_T    = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] MAX_T    = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0] AMB_T    = TEMP_W'(AMBIENT);
    localparam logic [TEMP_W-1:0] INIT_T   = TEMP_W'(TEMP_INIT);
    localparam int                LO       = int'(TEMP_MIN);
    localparam int                HI       = int'(TEMP_MAX);

    plant_state_t      state;
    plant_state_t      state_nxt;
    logic              clr;
    logic              hold;
    logic              tc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  term;
    logic [TEMP_W-1:0] temp_nxt;
    int                delta;
    int                sum;

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .hold     (hold),
        .load     (1'b0),
        .load_val ('0),
        .term     (term),
        .count    (count),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, timer control and the clamped next temperature.
    always_comb begin
        state_nxt = decode_cmd(heating, cooling);
        clr       = (state_nxt != state);
        hold      = (state == FAULT);
        term      = (state == IDLE) ? DRIFT_TC : STEP_TC;
        delta     = 0;
        if (tc) begin
            case (state)
                HEAT:    delta = 1;
                COOL:    delta = -1;
                IDLE: begin
                    if (temp < AMB_T) begin
                        delta = 1;
                    end else if (temp > AMB_T) begin
                        delta = -1;
                    end
                end
                default: delta = 0;
            endcase
        end
`ifdef PLANT_DISTURB_EN
        if (dist_req) begin
            delta = delta + (dist_up ? 1 : -1);
        end
`else
        delta = delta + 0;
`endif
        // Clamp the net move so limits hold even when two steps coincide.
        sum = int'(temp) + delta;
        if (sum > HI) begin
            sum = HI;
        end else if (sum < LO) begin
            sum = LO;
        end
        temp_nxt = TEMP_W'(sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            temp     <= INIT_T;
            temp_chg <= 1'b0;
            at_limit <= (INIT_T == MIN_T) || (INIT_T == MAX_T);
            fault    <= 1'b0;
        end else begin
            temp     <= temp_nxt;
            temp_chg <= (temp_nxt != temp);
            at_limit <= (temp_nxt == MIN_T) || (temp_nxt == MAX_T);
            fault    <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_room_plant.sv
// Directed self-checking bench for room_plant with default parameters.
// Define PLANT_DISTURB_EN to also exercise the disturbance ports.
module tb_room_plant;

    logic       clk;
    logic       rst;
    logic       heating;
    logic       cooling;
    logic [4:0] temp;
    logic       temp_chg;
    logic       at_limit;
    logic       fault;
`ifdef PLANT_DISTURB_EN
    logic       dist_req;
    logic       dist_up;
`endif

    int errors = 0;
    int checks = 0;

    room_plant dut (
        .clk      (clk),
        .rst      (rst),
        .heating  (heating),
        .cooling  (cooling),
`ifdef PLANT_DISTURB_EN
        .dist_req (dist_req),
        .dist_up  (dist_up),
`endif
        .temp     (temp),
        .temp_chg (temp_chg),
        .at_limit (at_limit),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e, input int t, input int chg,
                             input int lim, input int flt);
        check($sformatf("%s e%0d temp", tag, e), int'(temp), t);
        check($sformatf("%s e%0d temp_chg", tag, e), int'(temp_chg), chg);
        check($sformatf("%s e%0d at_limit", tag, e), int'(at_limit), lim);
        check($sformatf("%s e%0d fault", tag, e), int'(fault), flt);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
`ifdef PLANT_DISTURB_EN
        dist_req = 1'b0;
        dist_up  = 1'b0;
`endif
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int t;

        rst     = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
`ifdef PLANT_DISTURB_EN
        dist_req = 1'b0;
        dist_up  = 1'b0;
`endif

        // Reset values, then idle drift 20 -> 19 -> 18 and hold.
        do_reset();
        check_out("reset", 0, 20, 0, 0, 0);
        for (int e = 1; e <= 26; e++) begin
            tick();
            t = (e < 8) ? 20 : ((e < 16) ? 19 : 18);
            check_out("drift", e, t, int'(e == 8 || e == 16), 0, 0);
        end

        // A reset in the middle of a drift count discards the partial count.
        do_reset();
        repeat (5) tick();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_out("rst_mid", e, (e < 8) ? 20 : 19, int'(e == 8), 0, 0);
        end

        // Heating from 20 up to saturation at 31.
        do_reset();
        heating = 1'b1;
        tick();
        check_out("heat", 0, 20, 0, 0, 0);
        for (int e = 1; e <= 56; e++) begin
            tick();
            t = 20 + e / 4;
            if (t > 31) t = 31;
            check_out("heat", e, t, int'((e % 4 == 0) && (e <= 44)), int'(t == 31), 0);
        end

        // Cooling from 31 down to saturation at 0.
        heating = 1'b0;
        cooling = 1'b1;
        tick();
        check_out("cool", 0, 31, 0, 1, 0);
        for (int e = 1; e <= 136; e++) begin
            tick();
            t = 31 - e / 4;
            if (t < 0) t = 0;
            check_out("cool", e, t, int'((e % 4 == 0) && (e <= 124)), int'(t == 0 || t == 31), 0);
        end

        // Both commands at 25 freeze temp and raise fault; release into COOL.
        do_reset();
        heating = 1'b1;
        tick();
        repeat (20) tick();
        check_out("to25", 20, 25, 1, 0, 0);
        cooling = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            check_out("fault", e, 25, 0, 0, 1);
        end
        heating = 1'b0;
        tick();
        check_out("release", 0, 25, 0, 0, 0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check_out("release", e, (e < 4) ? 25 : 24, int'(e == 4), 0, 0);
        end

        // Heating toggling every 3 cycles never reaches a terminal count.
        do_reset();
        for (int c = 0; c < 36; c++) begin
            heating = ((c / 3) % 2 == 0);
            tick();
            check_out("toggle", c, 20, 0, 0, 0);
        end

`ifdef PLANT_DISTURB_EN
        // Disturbance up coinciding with a HEAT step at 29 gives 31 in one change.
        do_reset();
        heating = 1'b1;
        tick();
        repeat (36) tick();
        check_out("d29", 36, 29, 1, 0, 0);
        repeat (3) tick();
        dist_req = 1'b1;
        dist_up  = 1'b1;
        tick();
        dist_req = 1'b0;
        check_out("d29", 40, 31, 1, 1, 0);
        tick();
        check_out("d29", 41, 31, 0, 1, 0);

        // Same coincidence at 30 clamps to 31.
        do_reset();
        heating = 1'b1;
        tick();
        repeat (40) tick();
        check_out("d30", 40, 30, 1, 0, 0);
        repeat (3) tick();
        dist_req = 1'b1;
        dist_up  = 1'b1;
        tick();
        dist_req = 1'b0;
        check_out("d30", 44, 31, 1, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
